// File: rtl/bicubic_weight_gen.sv
// Keys bicubic weight generator: all four tap weights for one phase t through a
// stall-able pipeline (input capture + 4 stages) carrying a tag sideband.
module bicubic_weight_gen #(
  parameter int FRAC_W = 8,
  parameter int A_W    = 9,
  parameter int OUT_W  = FRAC_W + 2,
  parameter int TAG_W  = 16,
  parameter bit NORM   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FRAC_W-1:0]       t,
  input  logic [A_W-1:0]          a_mag,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] w0,
  output logic signed [OUT_W-1:0] w1,
  output logic signed [OUT_W-1:0] w2,
  output logic signed [OUT_W-1:0] w3,
  output logic [TAG_W-1:0]        out_tag
);
  localparam int STAGES = 4;
  localparam int MW     = (A_W > FRAC_W) ? A_W : FRAC_W;
  localparam int EW     = 4*FRAC_W + MW + 4;
  localparam int SH     = 3*FRAC_W;
  localparam int P2W    = 2*FRAC_W;
  localparam int P3W    = 3*FRAC_W + 1;
  localparam logic signed [EW-1:0] ONE_E   = EW'(1) <<< FRAC_W;
  localparam logic signed [EW-1:0] TWO_E   = EW'(2) <<< FRAC_W;
  localparam logic signed [EW-1:0] THREE_E = EW'(3) <<< FRAC_W;
  localparam logic signed [EW-1:0] ONE4_E  = EW'(1) <<< (4*FRAC_W);
  localparam logic signed [EW-1:0] HALF_E  = EW'(1) <<< (SH-1);
  localparam logic signed [EW-1:0] MAX_E   = (EW'(1) <<< (OUT_W-1)) - EW'(1);
  localparam logic signed [EW-1:0] MIN_E   = -(EW'(1) <<< (OUT_W-1));
  localparam logic [FRAC_W:0]      ONE_U   = {1'b1, {FRAC_W{1'b0}}};

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [EW-1:0] v);
    if (v > MAX_E)      sat = MAX_E[OUT_W-1:0];
    else if (v < MIN_E) sat = MIN_E[OUT_W-1:0];
    else                sat = v[OUT_W-1:0];
  endfunction

  logic [STAGES:0]            r_vld_pipe;
  logic [STAGES:0][TAG_W-1:0] r_tag_pipe;
  logic                       w_en;
  logic [FRAC_W-1:0]          r_s0_t, r_s1_t;
  logic [A_W-1:0]             r_s0_a, r_s1_a, r_s2_a;
  logic [FRAC_W:0]            w_u0, r_s1_u;
  logic [P2W-1:0]             r_s1_t2, r_s2_t2;
  logic [P2W:0]               r_s1_u2, r_s2_u2;
  logic [SH-1:0]              r_s2_t3;
  logic [P3W-1:0]             r_s2_u3, r_s2_p0, r_s2_p3;
  logic signed [EW-1:0]       r_s3_e [4];
  logic signed [EW-1:0]       w_a, w_t2, w_u2, w_t3, w_u3, w_p0, w_p3, w_nsum;
  logic signed [OUT_W-1:0]    w_ws [4];
  logic signed [OUT_W-1:0]    w_w1;

  assign w_en      = !(out_valid && !out_ready);
  assign in_ready  = w_en;
  assign out_valid = r_vld_pipe[STAGES];
  assign out_tag   = r_tag_pipe[STAGES];
  assign w_u0      = ONE_U - {1'b0, r_s0_t};

  assign w_a  = EW'(r_s2_a);
  assign w_t2 = EW'(r_s2_t2);
  assign w_u2 = EW'(r_s2_u2);
  assign w_t3 = EW'(r_s2_t3);
  assign w_u3 = EW'(r_s2_u3);
  assign w_p0 = EW'(r_s2_p0);
  assign w_p3 = EW'(r_s2_p3);

  // Round half toward +inf, then clamp each tap to the output range.
  for (genvar k = 0; k < 4; k++) begin : g_tap
    logic signed [EW-1:0] w_rnd;
    assign w_rnd   = (r_s3_e[k] + HALF_E) >>> SH;
    assign w_ws[k] = sat(w_rnd);
  end

  assign w_nsum = ONE_E - (EW'(w_ws[0]) + EW'(w_ws[2]) + EW'(w_ws[3]));
  assign w_w1   = NORM ? sat(w_nsum) : w_ws[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
      r_s0_t     <= '0;
      r_s0_a     <= '0;
      r_s1_t     <= '0;
      r_s1_u     <= '0;
      r_s1_t2    <= '0;
      r_s1_u2    <= '0;
      r_s1_a     <= '0;
      r_s2_t2    <= '0;
      r_s2_u2    <= '0;
      r_s2_t3    <= '0;
      r_s2_u3    <= '0;
      r_s2_p0    <= '0;
      r_s2_p3    <= '0;
      r_s2_a     <= '0;
      r_s3_e     <= '{default: '0};
      w0         <= '0;
      w1         <= '0;
      w2         <= '0;
      w3         <= '0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], in_valid};
      r_tag_pipe <= {r_tag_pipe[STAGES-1:0], in_tag};
      r_s0_t     <= t;
      r_s0_a     <= a_mag;
      r_s1_t     <= r_s0_t;
      r_s1_u     <= w_u0;
      r_s1_t2    <= P2W'(r_s0_t) * P2W'(r_s0_t);
      r_s1_u2    <= (P2W+1)'(w_u0) * (P2W+1)'(w_u0);
      r_s1_a     <= r_s0_a;
      r_s2_t2    <= r_s1_t2;
      r_s2_u2    <= r_s1_u2;
      r_s2_t3    <= SH'(r_s1_t2) * SH'(r_s1_t);
      r_s2_u3    <= P3W'(r_s1_u2) * P3W'(r_s1_u);
      // Outer branch factors as -A*(x-1)(x-2)^2, i.e. -A*t*(1-t)^2 and -A*(1-t)*t^2.
      r_s2_p0    <= P3W'(r_s1_t) * P3W'(r_s1_u2);
      r_s2_p3    <= P3W'(r_s1_u) * P3W'(r_s1_t2);
      r_s2_a     <= r_s1_a;
      r_s3_e[0]  <= -(w_a * w_p0);
      r_s3_e[1]  <= (TWO_E - w_a) * w_t3 - (((THREE_E - w_a) * w_t2) <<< FRAC_W) + ONE4_E;
      r_s3_e[2]  <= (TWO_E - w_a) * w_u3 - (((THREE_E - w_a) * w_u2) <<< FRAC_W) + ONE4_E;
      r_s3_e[3]  <= -(w_a * w_p3);
      w0         <= w_ws[0];
      w1         <= w_w1;
      w2         <= w_ws[2];
      w3         <= w_ws[3];
    end
  end
endmodule

// File: tb/tb_bicubic_weight_gen.sv
// Bench for bicubic_weight_gen: NORM=1 and NORM=0 instances driven in lockstep,
// checked every cycle against a polynomial reference model and a latency scoreboard.
module tb_bicubic_weight_gen;
  localparam int S = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, out_ready;
  logic [7:0]        t;
  logic [8:0]        a_mag;
  logic [15:0]       in_tag;
  logic              ir_a, ov_a, ir_b, ov_b;
  logic signed [9:0] w0a, w1a, w2a, w3a, w0b, w1b, w2b, w3b;
  logic [15:0]       tag_a, tag_b;

  int n_vec = 0;
  int n_err = 0;
  int ecnt = 0;
  int tag_ctr = 0;
  int alist [4] = '{0, 128, 192, 511};

  typedef struct {
    int tag; int c; int w0; int w1; int w2; int w3; int w1n;
  } samp_t;
  samp_t q[$];

  always #5 clk = ~clk;

  bicubic_weight_gen dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .t(t), .a_mag(a_mag),
    .in_tag(in_tag), .out_valid(ov_a), .out_ready(out_ready),
    .w0(w0a), .w1(w1a), .w2(w2a), .w3(w3a), .out_tag(tag_a));

  bicubic_weight_gen #(.NORM(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b), .t(t), .a_mag(a_mag),
    .in_tag(in_tag), .out_valid(ov_b), .out_ready(out_ready),
    .w0(w0b), .w1(w1b), .w2(w2b), .w3(w3b), .out_tag(tag_b));

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Kernel polynomials scaled by 2^32, with X the distance scaled by 2^8.
  function automatic longint e_in(input longint x, input longint a);
    return (2*S - a)*x*x*x - (3*S - a)*x*x*S + longint'(S)*S*S*S;
  endfunction
  function automatic longint e_out(input longint x, input longint a);
    return -a*x*x*x + 5*a*x*x*S - 8*a*x*S*S + 4*a*S*S*S;
  endfunction
  function automatic int sat(input longint v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return int'(v);
  endfunction
  function automatic int rs(input longint e);
    longint r;
    r = (e + 64'sd8388608) >>> 24;
    return sat(r);
  endfunction
  function automatic samp_t model(input int tt, input int aa);
    samp_t s;
    longint x, a;
    x = tt; a = aa;
    s.w0  = rs(e_out(S + x, a));
    s.w1  = rs(e_in(x, a));
    s.w2  = rs(e_in(S - x, a));
    s.w3  = rs(e_out(2*S - x, a));
    s.w1n = sat(256 - (s.w0 + s.w2 + s.w3));
    s.tag = 0;
    s.c   = 0;
    return s;
  endfunction

  always @(negedge clk) begin : mon
    bit    exp_ov, exp_en;
    samp_t s;
    if (rst) begin
      chk("rst_out_valid_a", int'(ov_a), 0);
      chk("rst_out_valid_b", int'(ov_b), 0);
      chk("rst_in_ready_a", int'(ir_a), 1);
      chk("rst_w_a", int'(w0a) | int'(w1a) | int'(w2a) | int'(w3a), 0);
      chk("rst_w_b", int'(w0b) | int'(w1b) | int'(w2b) | int'(w3b), 0);
      chk("rst_tag", int'(tag_a) | int'(tag_b), 0);
      q.delete();
    end else begin
      exp_ov = (q.size() > 0) && (ecnt == q[0].c + 5);
      exp_en = !(exp_ov && !out_ready);
      chk("out_valid_a", int'(ov_a), int'(exp_ov));
      chk("out_valid_b", int'(ov_b), int'(exp_ov));
      chk("in_ready_a", int'(ir_a), int'(exp_en));
      chk("in_ready_b", int'(ir_b), int'(exp_en));
      if (exp_ov && ov_a) begin
        chk("w0_a", int'(w0a), q[0].w0);
        chk("w1_a_norm", int'(w1a), q[0].w1n);
        chk("w2_a", int'(w2a), q[0].w2);
        chk("w3_a", int'(w3a), q[0].w3);
        chk("tag_a", int'(tag_a), q[0].tag);
        chk("sum_a", int'(w0a) + int'(w1a) + int'(w2a) + int'(w3a), 256);
      end
      if (exp_ov && ov_b) begin
        chk("w0_b", int'(w0b), q[0].w0);
        chk("w1_b", int'(w1b), q[0].w1);
        chk("w2_b", int'(w2b), q[0].w2);
        chk("w3_b", int'(w3b), q[0].w3);
        chk("tag_b", int'(tag_b), q[0].tag);
      end
      if (exp_ov && out_ready) void'(q.pop_front());
      if (in_valid && exp_en) begin
        s     = model(int'(t), int'(a_mag));
        s.tag = int'(in_tag);
        s.c   = ecnt;
        q.push_back(s);
      end
      if (exp_en) ecnt++;
    end
  end

  task automatic directed(input int tt, input int aa, input int e0, input int e1,
                          input int e2, input int e3);
    int  k;
    int  tg;
    bit  got;
    tg        = tag_ctr;
    in_valid  = 1'b1;
    t         = 8'(tt);
    a_mag     = 9'(aa);
    in_tag    = 16'(tag_ctr);
    tag_ctr++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    k = 0;
    while (!got && k < 10) begin
      @(posedge clk); #1;
      k++;
      if (ov_a) begin
        got = 1'b1;
        chk("dir_latency", k, 4);
        chk("dir_w0", int'(w0a), e0);
        chk("dir_w1", int'(w1a), e1);
        chk("dir_w2", int'(w2a), e2);
        chk("dir_w3", int'(w3a), e3);
        chk("dir_w1_b", int'(w1b), e1);
        chk("dir_tag", int'(tag_a), tg & 16'hffff);
      end
    end
    if (!got) chk("dir_timeout", 0, 1);
  endtask

  task automatic run(input int n, input int vpct, input int rpct, input bit sweep);
    int sent, cyc, idx;
    bit have, acc;
    sent = 0; cyc = 0; idx = 0; have = 1'b0;
    while (sent < n && cyc < n*20 + 100) begin
      if (!have) begin
        if (int'($urandom_range(99)) < vpct) begin
          have = 1'b1;
          if (sweep) begin
            t     = 8'(idx % 256);
            a_mag = 9'(alist[(idx / 256) % 4]);
          end else begin
            t     = 8'($urandom_range(255));
            a_mag = 9'($urandom_range(511));
          end
          in_tag = 16'(tag_ctr);
          tag_ctr++;
          idx++;
        end else begin
          t     = 8'($urandom_range(255));
          a_mag = 9'($urandom_range(511));
        end
      end
      in_valid = have;
      if (rpct < 0) begin
        if ($urandom_range(99) < 30) out_ready = !out_ready;
      end else begin
        out_ready = (int'($urandom_range(99)) < rpct);
      end
      @(negedge clk);
      acc = in_valid && ir_a;
      @(posedge clk); #1;
      if (acc) begin
        have = 1'b0;
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    if (sent < n) chk("run_timeout", sent, n);
  endtask

  task automatic drain();
    int k;
    k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    t = '0; a_mag = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    directed(0,   128,   0, 256,   0,   0);
    directed(128, 128, -16, 144, 144, -16);
    directed(128, 192, -24, 152, 152, -24);
    directed(128, 0,     0, 128, 128,   0);

    run(10, 100, -1, 1'b0);
    drain();
    run(1024, 100, 85, 1'b1);
    drain();

    // Reset with a sample at the output and several behind it.
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      t        = 8'($urandom_range(255));
      a_mag    = 9'($urandom_range(511));
      in_tag   = 16'(tag_ctr);
      tag_ctr++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_out_valid", int'(ov_a), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", int'(ov_a) | int'(ov_b), 0);
    chk("async_rst_w", int'(w0a) | int'(w1a) | int'(w2a) | int'(w3a), 0);
    chk("async_rst_tag", int'(tag_a), 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    directed(128, 128, -16, 144, 144, -16);

    run(200, 50, 70, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end
endmodule
